// File: rtl/pg_precompute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pg_precompute_stage
//  Purpose  : Level-1 front end for parallel-prefix adders. Forms per-bit
//             generate (a & b) and propagate (a ^ b) in the first register
//             stage, then carries G/P, carry-in and a valid flag through
//             DEPTH-1 pure buffer stages so the prefix tree receives
//             time-aligned vectors.
//  Ports    : clk       - rising-edge clock
//             rst       - asynchronous active-high reset (clears every stage)
//             hold      - freezes every stage, valid bits included
//             in_valid  - qualifies a/b/cin this cycle
//             a, b      - operands, WIDTH bits
//             cin       - carry-in
//             out_valid - qualifies g/p/cin_out
//             g, p      - registered generate / propagate vectors
//             cin_out   - carry-in delayed by DEPTH stages
//  Options  : PG_CIN_MERGE_EN - when defined, bit 0 absorbs the carry-in
//             (g[0] = G0 | P0&cin, p[0] = 0); cin_out is still delayed.
//  Revision : 1.0 - initial release
// ============================================================================
module pg_precompute_stage #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] p,
   output logic             cin_out
);

   // Pipeline storage; index 0 is the G/P-forming stage, DEPTH-1 drives ports.
   logic [WIDTH-1:0] r_g [DEPTH];
   logic [WIDTH-1:0] r_p [DEPTH];
   logic             r_v [DEPTH];
   logic             r_c [DEPTH];

   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;

   // Bitwise generate/propagate; no information crosses bit positions.
   always_comb begin
      w_g = a & b;
      w_p = a ^ b;
`ifdef PG_CIN_MERGE_EN
      // Fold carry-in into bit 0 so the tree sees a carry-free LSB group.
      // p[0] is forced low, which keeps g & p == 0 intact.
      w_g[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
      w_p[0] = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_g[k] <= '0;
            r_p[k] <= '0;
            r_v[k] <= 1'b0;
            r_c[k] <= 1'b0;
         end
      end else if (!hold) begin
         // Data loads regardless of in_valid; only the valid bit qualifies it.
         r_g[0] <= w_g;
         r_p[0] <= w_p;
         r_v[0] <= in_valid;
         r_c[0] <= cin;
         for (int k = 1; k < DEPTH; k++) begin
            r_g[k] <= r_g[k-1];
            r_p[k] <= r_p[k-1];
            r_v[k] <= r_v[k-1];
            r_c[k] <= r_c[k-1];
         end
      end
   end

   assign g         = r_g[DEPTH-1];
   assign p         = r_p[DEPTH-1];
   assign out_valid = r_v[DEPTH-1];
   assign cin_out   = r_c[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_pg_precompute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pg_precompute_stage
//  Purpose  : Self-checking bench for pg_precompute_stage (WIDTH=32, DEPTH=2).
//             A queue-based reference model of accepted samples is compared
//             against the DUT every negative clock edge; directed tests pin
//             literal values for reset, basic PG, streaming, hold and the
//             optional carry-in merge (PG_CIN_MERGE_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pg_precompute_stage;

   localparam int WIDTH = 32;
   localparam int DEPTH = 2;
`ifdef PG_CIN_MERGE_EN
   localparam logic [WIDTH-1:0] P0MASK = 32'hFFFF_FFFE;
`else
   localparam logic [WIDTH-1:0] P0MASK = 32'hFFFF_FFFF;
`endif

   typedef struct packed {
      logic             v;
      logic             c;
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
   } pg_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             hold;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic             cin_out;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   pg_t model_q[$];

   pg_precompute_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .hold     (hold),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .out_valid(out_valid),
      .g        (g),
      .p        (p),
      .cin_out  (cin_out)
   );

   always #5 clk = ~clk;

   // Expected stage-1 contents for one sample, straight from the bit rules.
   function automatic pg_t pg_of(logic [WIDTH-1:0] av, logic [WIDTH-1:0] bv,
                                 logic cv, logic vv);
      pg_t r;
      r.v = vv;
      r.c = cv;
      for (int i = 0; i < WIDTH; i++) begin
         r.g[i] = av[i] & bv[i];
         r.p[i] = av[i] ^ bv[i];
      end
`ifdef PG_CIN_MERGE_EN
      r.g[0] = (av[0] & bv[0]) | ((av[0] ^ bv[0]) & cv);
      r.p[0] = 1'b0;
`endif
      return r;
   endfunction

   // Output after DEPTH accepted edges equals the sample accepted DEPTH
   // edges ago; before that the reset value (all zero) is still visible.
   function automatic pg_t model_out();
      pg_t z;
      z = '0;
      if (model_q.size() == DEPTH) return model_q[0];
      return z;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_q.delete();
      end else if (!hold) begin
         model_q.push_back(pg_of(a, b, cin, in_valid));
         if (model_q.size() > DEPTH) void'(model_q.pop_front());
      end
   end

   function automatic pg_t dut_out();
      pg_t r;
      r.v = out_valid;
      r.c = cin_out;
      r.g = g;
      r.p = p;
      return r;
   endfunction

   task automatic check(string name, pg_t act, pg_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got v=%b c=%b g=%h p=%h, expected v=%b c=%b g=%h p=%h",
                  name, act.v, act.c, act.g, act.p, exp.v, exp.c, exp.g, exp.p);
      end
   endtask

   // Continuous comparison against the model plus the g&p invariant.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model", dut_out(), model_out());
         checks++;
         if ((g & p) !== '0) begin
            errors++;
            $display("FAIL invariant: g&p=%h, expected 0", g & p);
         end
      end
   end

   task automatic drive(logic [WIDTH-1:0] av, logic [WIDTH-1:0] bv, logic cv,
                        logic vv, logic hv);
      @(posedge clk);
      #1;
      a = av; b = bv; cin = cv; in_valid = vv; hold = hv;
   endtask

   function automatic pg_t lit(logic vv, logic cv, logic [WIDTH-1:0] gv,
                               logic [WIDTH-1:0] pv);
      pg_t r;
      r.v = vv; r.c = cv; r.g = gv; r.p = pv;
      return r;
   endfunction

   initial begin
      pg_t idle_exp;
      rst = 1'b1; hold = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
      idle_exp = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", dut_out(), idle_exp);
      rst = 1'b0;
      chk_en = 1'b1;

      // Basic PG
      drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); @(negedge clk);
      check("basic_pg", dut_out(), lit(1'b1, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE));

      // Streaming, back-to-back
      drive(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b1, 1'b0);
      drive(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
      drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("stream_0", dut_out(), lit(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF & P0MASK));
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("stream_1", dut_out(), lit(1'b1, 1'b0, 32'h1234_5678, 32'h0));
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("stream_2", dut_out(), lit(1'b1, 1'b0, 32'h0, 32'h0));

      // Hold for three cycles with two vectors in flight
      drive(32'h0000_FF00, 32'h00FF_0F00, 1'b1, 1'b1, 1'b0);
      drive(32'hF0F0_0002, 32'h0FF0_0002, 1'b0, 1'b1, 1'b0);
      drive(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      check("hold_0", dut_out(), lit(1'b1, 1'b1, 32'h0000_0F00, 32'h00FF_F000));
      drive(32'hCAFE_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      check("hold_1", dut_out(), lit(1'b1, 1'b1, 32'h0000_0F00, 32'h00FF_F000));
      drive(32'h7777_7777, 32'h8888_8888, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      check("hold_2", dut_out(), lit(1'b1, 1'b1, 32'h0000_0F00, 32'h00FF_F000));
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("hold_3", dut_out(), lit(1'b1, 1'b1, 32'h0000_0F00, 32'h00FF_F000));
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("hold_rel", dut_out(), lit(1'b1, 1'b0, 32'h00F0_0002, 32'hFF00_0000));
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("hold_nodup", dut_out(), idle_exp);

      // Asynchronous reset with data in flight
      drive(32'h0000_00F0, 32'h0000_00FF, 1'b1, 1'b1, 1'b0);
      drive(32'h0000_0F00, 32'h0000_0F00, 1'b1, 1'b1, 1'b0);
      drive(32'h0000_0F00, 32'h0000_0F00, 1'b1, 1'b1, 1'b0);
      check("pre_rst", dut_out(), lit(1'b1, 1'b1, 32'h0000_00F0, 32'h0000_000F));
      rst = 1'b1;
      #1;
      check("async_rst", dut_out(), idle_exp);
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      drive(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 1'b0);
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("post_rst_lat1", dut_out(), idle_exp);
      @(posedge clk); @(negedge clk);
      check("post_rst_lat2", dut_out(), lit(1'b1, 1'b0, 32'h0000_0001, 32'h0000_0006 & P0MASK));

`ifdef PG_CIN_MERGE_EN
      drive(32'h0, 32'h1, 1'b1, 1'b1, 1'b0);
      drive(32'h0, 32'h1, 1'b0, 1'b1, 1'b0);
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("merge_cin1", dut_out(), lit(1'b1, 1'b1, 32'h1, 32'h0));
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("merge_cin0", dut_out(), lit(1'b1, 1'b0, 32'h0, 32'h0));
`endif

      // Randomized traffic, checked each cycle by the model process
      for (int n = 0; n < 1000; n++) begin
         drive($urandom(), $urandom(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0));
         if ($urandom_range(0, 99) == 0) rst = 1'b1;
         else rst = 1'b0;
      end
      rst = 1'b0;
      repeat (3) drive('0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pg_precompute_stage.md
Name: pg_precompute_stage

Overview:
- Pipelined front-end (level-1) stage for parallel-prefix adders (Sklansky, Kogge-Stone, etc.).
- Per bit, forms generate G = A AND B and propagate P = A XOR B.
- Passes G/P and carry-in through a chain of pure buffer registers, so the prefix network receives time-aligned G/P vectors with a valid flag.
- Sits between operand registers and the prefix tree.

Parameters:
- WIDTH, 32, operand width in bits; legal range >= 2.
- DEPTH, 2, total register stages; stage 1 computes G/P, stages 2..DEPTH are pure buffers; legal range >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  when high, every pipeline stage keeps its contents.
- in_valid  in  1  qualifies a/b/cin this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  qualifies g/p/cin_out.
- g  out  WIDTH  registered bitwise generate vector.
- p  out  WIDTH  registered bitwise propagate vector.
- cin_out  out  1  carry-in, delayed by DEPTH stages.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- While rst is high, every stage clears: out_valid=0, g=0, p=0, cin_out=0.
  - Reset asserted mid-operation discards all in-flight data immediately, without waiting for a clock edge.
  - The first capture after release happens on the first clk rising edge with rst low.
- Stage 1, on each rising edge with hold=0:
  - captures g1[i] = a[i] & b[i] and p1[i] = a[i] ^ b[i] for all i;
  - captures cin1 = cin and v1 = in_valid.
- Stage k (2..DEPTH), on each rising edge with hold=0: copies stage k-1 unchanged (buffer cell: P in -> P out, G in -> G out).
- Outputs are driven directly from stage DEPTH registers; there is no combinational path from inputs to outputs.
- Latency: exactly DEPTH cycles from sampling (in_valid=1, hold=0) to out_valid=1 with the corresponding data.
- Throughput: one vector per cycle; back-to-back in_valid is accepted with no bubbles.
- Data registers load regardless of in_valid. Data with out_valid=0 is don't-care to consumers, but must still equal the function of whatever was sampled.
- hold=1 freezes all stages, including valid bits. Inputs presented during hold are ignored, not queued.
- hold and rst both high: rst wins.
- Invariant: g & p == 0 for every output vector (a bit cannot both generate and propagate).
- Pure bitwise logic: no carries cross bit positions inside this block.

Optional Feature:
- Macro: PG_CIN_MERGE_EN.
- Defined (prefix-with-carry-in form): bit 0 folds carry-in into stage 1.
  - g1[0] = (a[0]&b[0]) | ((a[0]^b[0]) & cin).
  - p1[0] = 0.
  - All other bits unchanged; cin_out still carries the delayed cin.
  - The invariant g & p == 0 still holds.
- Undefined: bit 0 is treated like every other bit; the downstream tree consumes cin_out separately.

Test Plan:
- Reset: assert rst asynchronously mid-stream with valid data in flight -> g=0, p=0, out_valid=0, cin_out=0 immediately, before the next clk edge. Release rst -> first valid output appears DEPTH cycles after the first sampled in_valid.
- Basic PG (WIDTH=32, DEPTH=2, macro off): a=0xFFFFFFFF, b=0x00000001, cin=0, in_valid=1 -> two edges later out_valid=1, g=0x00000001, p=0xFFFFFFFE, cin_out=0.
- Streaming: three back-to-back vectors -> outputs match in order on three consecutive cycles after latency 2:
  - (0xA5A5A5A5, 0x5A5A5A5A) -> g=0x00000000, p=0xFFFFFFFF;
  - (0x12345678, 0x12345678) -> g=0x12345678, p=0;
  - (0, 0) -> g=0, p=0.
- Hold: assert hold for 3 cycles with two vectors in flight -> outputs and out_valid are frozen. After release, the vectors emerge in original order, with no loss or duplication.
- Random: 1000 random a/b/cin/in_valid/hold patterns against a reference model -> exact match; g&p==0 on every cycle.
- Macro on: a=0x00000000, b=0x00000001, cin=1 -> g=0x00000001, p=0x00000000, cin_out=1. With cin=0 on the same operands -> g=0x00000000, p=0x00000000.
